// File: rtl/pid_pkg.sv
// Shared widths and the signed clamp helper for the balance-control PID path.
package pid_pkg;

    localparam int ERR_W  = 16;
    localparam int DSAT_W = 10;

    // Clamp a signed value into the signed range of `width` bits; the caller
    // narrows the result with a size cast.
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] value,
                                                 input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/pid_err_gen_err_hist.sv
// Error history for the D path: DEPTH-entry shift register of clamped errors.
module err_hist
    import pid_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = DSAT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en,
    input  logic [W-1:0] din,
    output logic [W-1:0] oldest
);

    logic [DEPTH-1:0][W-1:0] hist_q;
    logic [DEPTH-1:0][W-1:0] hist_d;

    always_comb begin
        hist_d = hist_q;
        if (shift_en) begin
            hist_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) hist_q <= '0;
        else     hist_q <= hist_d;
    end

    assign oldest = hist_q[DEPTH-1];

endmodule

// File: rtl/pid_err_gen.sv
// PID front end: saturated error, D difference against an older sample, and a
// signed integrator that holds on overflow. One-cycle latency, full throughput.
module pid_err_gen
    import pid_pkg::*;
#(
    parameter int D_DEPTH = 2,
    parameter int I_W     = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld,
    input  logic [ERR_W-1:0]  ptch,
    input  logic [ERR_W-1:0]  setpt,
    input  logic              clr_integ,
    output logic [ERR_W-1:0]  signed_err,
    output logic [DSAT_W-1:0] signed_D_diff,
    output logic [I_W-1:0]    integ,
    output logic              ovr_I,
    output logic              out_vld
);

    logic signed [ERR_W:0]    diff;
    logic signed [ERR_W-1:0]  e16;
    logic signed [DSAT_W-1:0] e10;
    logic signed [DSAT_W-1:0] hist_old;
    logic signed [DSAT_W:0]   d_raw;
    logic signed [DSAT_W-1:0] d_sat;
    logic signed [I_W-1:0]    integ_sum;
    logic                     integ_ovf;

    logic signed [ERR_W-1:0]  err_q,     err_d;
    logic signed [DSAT_W-1:0] dd_q,      dd_d;
    logic signed [I_W-1:0]    integ_q,   integ_d;
    logic                     ovr_q,     ovr_d;
    logic                     out_vld_q, out_vld_d;

    err_hist #(
        .DEPTH (D_DEPTH),
        .W     (DSAT_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .shift_en (vld),
        .din      (e10),
        .oldest   (hist_old)
    );

    // Both subtractions are one bit wider than their operands so they never
    // wrap before the clamp.
    always_comb begin
        diff      = $signed({ptch[ERR_W-1], ptch}) - $signed({setpt[ERR_W-1], setpt});
        e16       = ERR_W'(sat_s(32'(diff), ERR_W));
        e10       = DSAT_W'(sat_s(32'(e16), DSAT_W));
        d_raw     = $signed({e10[DSAT_W-1], e10}) - $signed({hist_old[DSAT_W-1], hist_old});
        d_sat     = DSAT_W'(sat_s(32'(d_raw), DSAT_W));
        integ_sum = integ_q + I_W'(e10);
        // Overflow only when both operands agree in sign and the sum does not.
        integ_ovf = (integ_q[I_W-1] == e10[DSAT_W-1]) &&
                    (integ_sum[I_W-1] != integ_q[I_W-1]);
    end

    always_comb begin
        err_d     = err_q;
        dd_d      = dd_q;
        integ_d   = integ_q;
        ovr_d     = ovr_q;
        out_vld_d = 1'b0;
        if (vld) begin
            err_d     = e16;
            dd_d      = d_sat;
            out_vld_d = 1'b1;
        end
        if (clr_integ) begin
            integ_d = '0;
            ovr_d   = 1'b0;
        end else if (vld) begin
            if (integ_ovf) ovr_d   = 1'b1;
            else           integ_d = integ_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= '0;
            dd_q      <= '0;
            integ_q   <= '0;
            ovr_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            err_q     <= err_d;
            dd_q      <= dd_d;
            integ_q   <= integ_d;
            ovr_q     <= ovr_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign signed_err    = err_q;
    assign signed_D_diff = dd_q;
    assign integ         = integ_q;
    assign ovr_I         = ovr_q;
    assign out_vld       = out_vld_q;

endmodule
